// File: rtl/seven_segment_scan_pkg.sv
// rtl/seven_segment_scan_pkg.sv - shared state encoding and slot-timing clamps for the scan controller
package seven_segment_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  localparam int MIN_PERIOD = 2;
  localparam int MIN_BLANK  = 1;

  function automatic logic [31:0] clamp_period(input logic [31:0] period);
    return (period < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : period;
  endfunction

  // Keeps at least one show cycle after the blank interval.
  function automatic logic [31:0] clamp_blank(input logic [31:0] blank, input logic [31:0] period);
    if (blank < 32'(MIN_BLANK)) return 32'(MIN_BLANK);
    if (blank > period - 32'd1) return period - 32'd1;
    return blank;
  endfunction

endpackage

// File: rtl/seven_segment_scan_controller_slot_timer.sv
// rtl/seven_segment_scan_controller_slot_timer.sv - per-slot cycle counter with blank/slot strobes
module scan_slot_timer
  import seven_segment_scan_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_period,
  input  logic [7:0]       i_blank,
  output logic             o_blank_done,
  output logic             o_slot_done
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_period;
  logic [DIV_W-1:0] r_blank;

  // Period and blank length are frozen at slot start so mid-slot edits wait for the next slot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_period <= DIV_W'(MIN_PERIOD);
      r_blank  <= DIV_W'(MIN_BLANK);
    end else if (i_start) begin
      r_cnt    <= '0;
      r_period <= DIV_W'(clamp_period(32'(i_period)));
      r_blank  <= DIV_W'(clamp_blank(32'(i_blank), clamp_period(32'(i_period))));
    end else if (i_run) begin
      r_cnt <= o_slot_done ? '0 : r_cnt + DIV_W'(1);
    end
  end

  assign o_blank_done = i_run && (r_cnt == r_blank - DIV_W'(1));
  assign o_slot_done  = i_run && (r_cnt == r_period - DIV_W'(1));

endmodule

// File: rtl/seven_segment_scan_controller.sv
// rtl/seven_segment_scan_controller.sv - time-multiplexed hex digit scanner with blanking and frame snapshot
module seven_segment_scan_controller
  import seven_segment_scan_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV_W  = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                i_enable,
  input  logic [4*DIGITS-1:0] i_value,
  input  logic                i_suppress_zeros,
  input  logic [DIV_W-1:0]    i_digit_period,
  input  logic [7:0]          i_blank_cycles,
  output logic [3:0]          o_number,
  output logic [DIGITS-1:0]   o_digit_sel,
  output logic                o_frame_done,
  output logic                o_busy
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  scan_state_t         r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_snapshot;
  logic [DIGITS-1:0]   r_mask;
  logic [3:0]          r_number;
  logic [DIGITS-1:0]   r_digit_sel;
  logic                r_frame_done;
  logic                r_busy;

  logic                w_blank_done;
  logic                w_slot_done;
  logic                w_start;
  logic                w_run;
  logic [IDX_W-1:0]    w_next_idx;
  logic [DIGITS-1:0]   w_mask;
  logic                w_zero_run;

  // A digit is blank only when it and every more-significant digit are zero.
  always_comb begin
    w_mask     = '0;
    w_zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_zero_run = w_zero_run && (i_value[i*4 +: 4] == 4'd0);
      w_mask[i]  = i_suppress_zeros && w_zero_run;
    end
  end

  assign w_run      = (r_state != ST_IDLE);
  assign w_next_idx = r_idx + IDX_W'(1);
  assign w_start    = ((r_state == ST_IDLE) && i_enable) ||
                      ((r_state == ST_SHOW) && w_slot_done && ((r_idx != LAST_IDX) || i_enable));

  scan_slot_timer #(.DIV_W(DIV_W)) u_slot_timer (
    .clock        (clock),
    .reset_n      (reset_n),
    .i_start      (w_start),
    .i_run        (w_run),
    .i_period     (i_digit_period),
    .i_blank      (i_blank_cycles),
    .o_blank_done (w_blank_done),
    .o_slot_done  (w_slot_done)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_snapshot   <= '0;
      r_mask       <= '0;
      r_number     <= 4'd0;
      r_digit_sel  <= '0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_digit_sel <= '0;
          if (i_enable) begin
            r_snapshot <= i_value;
            r_mask     <= w_mask;
            r_idx      <= '0;
            r_number   <= i_value[3:0];
            r_busy     <= 1'b1;
            r_state    <= ST_BLANK;
          end
        end
        ST_BLANK: begin
          r_digit_sel <= '0;
          r_number    <= r_snapshot[{r_idx, 2'b00} +: 4];
          if (w_blank_done) begin
            r_digit_sel <= r_mask[r_idx] ? '0 : (DIGITS'(1) << r_idx);
            r_state     <= ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (w_slot_done) begin
            r_digit_sel <= '0;
            if (r_idx != LAST_IDX) begin
              r_idx    <= w_next_idx;
              r_number <= r_snapshot[{w_next_idx, 2'b00} +: 4];
              r_state  <= ST_BLANK;
            end else begin
              r_frame_done <= 1'b1;
              r_idx        <= '0;
              if (i_enable) begin
                r_snapshot <= i_value;
                r_mask     <= w_mask;
                r_number   <= i_value[3:0];
                r_state    <= ST_BLANK;
              end else begin
                r_busy  <= 1'b0;
                r_state <= ST_IDLE;
              end
            end
          end
        end
        default: begin
          r_digit_sel <= '0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_number     = r_number;
  assign o_digit_sel  = r_digit_sel;
  assign o_frame_done = r_frame_done;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// tb/tb_seven_segment_scan_controller.sv - self-checking bench for seven_segment_scan_controller
module tb_seven_segment_scan_controller;

  localparam int DIGITS = 4;
  localparam int DIV_W  = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic        suppress_zeros = 1'b0;
  logic [15:0] value = 16'h0;
  logic [15:0] digit_period = 16'd4;
  logic [7:0]  blank_cycles = 8'd1;
  logic [3:0]  number;
  logic [3:0]  digit_sel;
  logic        frame_done;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  seven_segment_scan_controller #(.DIGITS(DIGITS), .DIV_W(DIV_W)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .i_enable         (enable),
    .i_value          (value),
    .i_suppress_zeros (suppress_zeros),
    .i_digit_period   (digit_period),
    .i_blank_cycles   (blank_cycles),
    .o_number         (number),
    .o_digit_sel      (digit_sel),
    .o_frame_done     (frame_done),
    .o_busy           (busy)
  );

  always #5 clock = ~clock;

  // Model: each slot is expanded into a queue of expected per-cycle outputs when it starts.
  typedef struct packed {
    logic [3:0] sel;
    logic [3:0] num;
    logic       fd;
    logic       busy;
  } exp_t;

  exp_t        q[$];
  exp_t        exp_now = '0;
  bit          m_running = 0;
  bit          m_went_idle = 0;
  int          m_idx = 0;
  logic [15:0] m_snap = '0;
  logic [3:0]  m_mask = '0;

  function automatic logic [3:0] zero_mask(input logic [15:0] v, input logic s);
    logic [3:0] m;
    m = '0;
    for (int i = 1; i < DIGITS; i++)
      if (s && ((v >> (4 * i)) == 16'd0)) m[i] = 1'b1;
    return m;
  endfunction

  task automatic push_slot(input int idx, input logic first_fd);
    int   p, b;
    exp_t e;
    p = (digit_period < 2) ? 2 : int'(digit_period);
    b = int'(blank_cycles);
    if (b < 1) b = 1;
    if (b > p - 1) b = p - 1;
    for (int k = 0; k < p; k++) begin
      e.sel  = (k < b || m_mask[idx]) ? 4'b0000 : 4'(1 << idx);
      e.num  = m_snap[4*idx +: 4];
      e.fd   = (k == 0) && first_fd;
      e.busy = 1'b1;
      q.push_back(e);
    end
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_running = 0;
      m_idx     = 0;
      m_snap    = '0;
      m_mask    = '0;
      exp_now   = '0;
    end else begin
      m_went_idle = 0;
      if (q.size() == 0) begin
        if (!m_running) begin
          if (enable) begin
            m_snap    = value;
            m_mask    = zero_mask(value, suppress_zeros);
            m_idx     = 0;
            m_running = 1;
            push_slot(0, 1'b0);
          end
        end else if (m_idx < DIGITS - 1) begin
          m_idx++;
          push_slot(m_idx, 1'b0);
        end else begin
          m_idx = 0;
          if (enable) begin
            m_snap = value;
            m_mask = zero_mask(value, suppress_zeros);
            push_slot(0, 1'b1);
          end else begin
            m_running   = 0;
            m_went_idle = 1;
            exp_now.sel  = 4'b0000;
            exp_now.fd   = 1'b1;
            exp_now.busy = 1'b0;
          end
        end
      end
      if (q.size() != 0) exp_now = q.pop_front();
      else if (!m_went_idle) begin
        exp_now.sel  = 4'b0000;
        exp_now.fd   = 1'b0;
        exp_now.busy = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    n_cmp++;
    if (digit_sel !== exp_now.sel || number !== exp_now.num ||
        frame_done !== exp_now.fd || busy !== exp_now.busy) begin
      n_bad++;
      $display("FAIL model_cycle t=%0t sel %b/%b num %h/%h fd %b/%b busy %b/%b (got/expected)",
               $time, digit_sel, exp_now.sel, number, exp_now.num,
               frame_done, exp_now.fd, busy, exp_now.busy);
    end
    n_cmp++;
    if ($countones(digit_sel) > 1) begin
      n_bad++;
      $display("FAIL onehot t=%0t digit_sel %b has more than one bit set", $time, digit_sel);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic wait_sel(input logic [3:0] target, input string name);
    int n;
    n = 0;
    while (digit_sel !== target && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (digit_sel !== target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout waiting for digit_sel %b, got %b", name, target, digit_sel);
    end
  endtask

  task automatic run_len(input logic [3:0] target, input string name, output int len);
    wait_sel(target, name);
    len = 0;
    while (digit_sel === target && len < 64) begin
      len++;
      @(negedge clock);
    end
  endtask

  task automatic wait_fd(input string name, output int cycles);
    cycles = 0;
    do begin
      @(negedge clock);
      cycles++;
    end while (frame_done !== 1'b1 && cycles < 300);
    if (frame_done !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout waiting for frame_done", name);
    end
  endtask

  initial begin
    int len, cyc, ones;
    logic [3:0] seen;

    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_number", 32'(number), 32'h0);
    check("reset_digit_sel", 32'(digit_sel), 32'h0);
    check("reset_frame_done", 32'(frame_done), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    #2 reset_n = 1'b1;
    @(negedge clock);

    // Basic scan.
    value = 16'h1234; digit_period = 16'd4; blank_cycles = 8'd1; enable = 1'b1;
    wait_sel(4'b0001, "basic_first");
    check("basic_num0", 32'(number), 32'h4);
    run_len(4'b0001, "basic_d0", len); check("basic_len0", len, 3);
    check("basic_num1", 32'(number), 32'h3);
    run_len(4'b0010, "basic_d1", len); check("basic_len1", len, 3);
    run_len(4'b0100, "basic_d2", len); check("basic_len2", len, 3);
    run_len(4'b1000, "basic_d3", len); check("basic_len3", len, 3);
    wait_fd("basic_fd_a", cyc);
    wait_fd("basic_fd_b", cyc); check("basic_frame_len", cyc, 16);

    // Clamping.
    digit_period = 16'd0; blank_cycles = 8'd0;
    wait_fd("clamp0_a", cyc); wait_fd("clamp0_b", cyc);
    wait_fd("clamp0_c", cyc); check("clamp0_frame_len", cyc, 8);
    digit_period = 16'd3; blank_cycles = 8'd9;
    wait_fd("clamp1_a", cyc); wait_fd("clamp1_b", cyc);
    wait_fd("clamp1_c", cyc); check("clamp1_frame_len", cyc, 12);
    run_len(4'b0001, "clamp1_d0", len); check("clamp1_show_len", len, 1);

    // Zero suppression.
    digit_period = 16'd4; blank_cycles = 8'd1; value = 16'h0050; suppress_zeros = 1'b1;
    wait_fd("zs_a", cyc); wait_fd("zs_b", cyc);
    ones = 0; seen = 4'b0000;
    for (int k = 0; k < 16; k++) begin
      if (digit_sel != 4'b0000) ones++;
      seen = seen | digit_sel;
      @(negedge clock);
    end
    check("zs_show_cycles", ones, 6);
    check("zs_digits_seen", 32'(seen), 32'h3);
    check("zs_frame_len", 32'(frame_done), 32'h1);

    // Snapshot holds for the whole frame.
    suppress_zeros = 1'b0; value = 16'h1111;
    wait_fd("snap_a", cyc); wait_fd("snap_b", cyc);
    wait_sel(4'b0010, "snap_d1");
    check("snap_num_d1", 32'(number), 32'h1);
    value = 16'h2222;
    wait_sel(4'b1000, "snap_d3");
    check("snap_num_d3", 32'(number), 32'h1);
    wait_fd("snap_c", cyc);
    wait_sel(4'b0001, "snap_next");
    check("snap_num_next", 32'(number), 32'h2);

    // Enable dropped mid-frame.
    wait_sel(4'b0100, "drop_d2");
    enable = 1'b0;
    wait_fd("drop_fd", cyc);
    check("drop_busy_at_fd", 32'(busy), 32'h0);
    check("drop_sel_at_fd", 32'(digit_sel), 32'h0);
    repeat (3) @(negedge clock);
    check("drop_busy_idle", 32'(busy), 32'h0);
    check("drop_sel_idle", 32'(digit_sel), 32'h0);

    // Mid-slot period change.
    enable = 1'b1;
    wait_sel(4'b0001, "cfg_d0");
    digit_period = 16'd8;
    run_len(4'b0010, "cfg_d1", len); check("cfg_show_len_d1", len, 7);

    // Asynchronous reset mid-show.
    wait_sel(4'b0100, "arst_d2");
    #2 reset_n = 1'b0;
    #1;
    check("arst_sel", 32'(digit_sel), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    @(negedge clock); @(negedge clock);
    #2 reset_n = 1'b1;
    cyc = 0;
    while (digit_sel === 4'b0000 && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    check("arst_restart_sel", 32'(digit_sel), 32'h1);
    check("arst_restart_num", 32'(number), 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
